slave_in_port: RTL and testbench
================================

SLAVE_IN_PORT -- requirements
Module: slave_in_port

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 12, address bits received serially per transaction.
REQ-002 SHALL have parameter DATA_LEN, default 8, bits per data word.
REQ-003 SHALL have parameter BURST_LEN, default 12, width of the serial burst-count field.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port write_en  in  1  level from bus master; requests a write transaction.
REQ-007 SHALL have port read_en  in  1  level from bus master; requests a read transaction.
REQ-008 SHALL have port approval_grant  in  1  bus ownership held by the master; low aborts the transaction.
REQ-009 SHALL have port rx_address  in  1  serial address line, LSB first.
REQ-010 SHALL have port rx_burst_number  in  1  serial burst line: one marker bit, then BURST_LEN bits LSB first.
REQ-011 SHALL have port rx_data  in  1  serial data line, LSB first, qualified by master_valid.
REQ-012 SHALL have port master_valid  in  1  rx_data holds a valid bit this cycle.
REQ-013 SHALL have port slave_ready  out  1  slave can accept a transaction.
REQ-014 SHALL have port mem_addr  out  ADDR_LEN  address for the current memory access.
REQ-015 SHALL have port mem_wdata  out  DATA_LEN  assembled write word.
REQ-016 SHALL have port mem_we  out  1  one-cycle write strobe.
REQ-017 SHALL have port mem_re  out  1  one-cycle read strobe.
REQ-018 SHALL have port burst_len  out  BURST_LEN  received burst count; valid once the header is complete.
REQ-019 SHALL have port rx_done  out  1  one-cycle pulse when the transaction completes normally.
REQ-020 SHALL have port error  out  1  one-cycle pulse when a transaction aborts.

Function
REQ-021 SHALL implement the states IDLE, HEADER, DATA and DONE; every output SHALL be registered.
REQ-022 IDLE: slave_ready=1; write_en=1 or read_en=1, with approval_grant=1, SHALL move to HEADER and clear all counters; write_en SHALL win if both are high.
REQ-023 HEADER, cycle k (k counted from 0, starting the cycle after entry):
- for k<ADDR_LEN, rx_address SHALL be stored as address bit k;
- at k=0, rx_burst_number SHALL be ignored (marker bit);
- for 1<=k<=BURST_LEN, rx_burst_number SHALL be stored as burst bit k-1.
REQ-024 HEADER SHALL last H = max(ADDR_LEN, BURST_LEN+1) cycles (13 at defaults); the header is then complete.
REQ-025 Read: on header completion, mem_re SHALL pulse 1 cycle with mem_addr = received address; the block SHALL then pass through DONE (rx_done=1) and return to IDLE.
REQ-026 Write: in HEADER and DATA, each cycle with master_valid=1 SHALL shift rx_data into bit position n (n = 0..DATA_LEN-1) of a word accumulator.
REQ-027 After DATA_LEN valid bits, the word SHALL be marked pending and n SHALL reset to 0.
REQ-028 A pending word SHALL be written only once the header is complete: mem_we=1, mem_wdata=word, mem_addr=(address + word_index) mod 2^ADDR_LEN, then word_index SHALL increment.
REQ-029 Expected word count W SHALL be 1 if burst_len=0, otherwise burst_len.
REQ-030 After the W-th mem_we, the block SHALL go to DONE (rx_done=1 for 1 cycle), then IDLE.
REQ-031 Completion of a new word while a word is still pending SHALL cause abort (overflow).
REQ-032 approval_grant=0 in HEADER or DATA SHALL cause abort, effective the same cycle; no mem_we or mem_re SHALL issue afterwards.
REQ-033 In DATA, 16 consecutive cycles with master_valid=0 SHALL cause abort (timeout).
REQ-034 Abort SHALL pulse error for 1 cycle, discard the pending word, return to IDLE, and leave rx_done low.
REQ-035 slave_ready SHALL be 1 in IDLE, HEADER and DATA, and 0 in DONE and in the abort cycle.
REQ-036 Bits still arriving after completion or abort SHALL be ignored until the next IDLE entry.

Reset
REQ-037 While reset=0, all outputs SHALL be 0 (including slave_ready), state SHALL be IDLE, and all counters and shift registers SHALL be cleared, independent of clk.
REQ-038 slave_ready SHALL rise on the first clk edge after reset returns to 1; reset mid-transaction SHALL issue no strobe.

Verification
REQ-039 Single write: addr 0x0A5, burst 0, data 0x3C serial from cycle 0 -> one mem_we with mem_addr=0x0A5, mem_wdata=0x3C; rx_done 1 cycle later.
REQ-040 Burst write: addr 0xFFE, burst 3, words 0x11, 0x22, 0x33 -> mem_we at addresses 0xFFE, 0xFFF, 0x000 (wrap); then rx_done.
REQ-041 Read: read_en, addr 0x123 -> mem_re once with mem_addr=0x123; no mem_we; rx_done pulses.
REQ-042 Abort: approval_grant dropped after 5 data bits -> error pulses once; no mem_we; next cycle IDLE with slave_ready=1.
REQ-043 Timeout: burst 2, second word stalls 16 cycles -> exactly one mem_we, then error.
REQ-044 Reset: reset low during DATA of a burst-4 write -> all outputs 0 immediately; after release slave_ready=1 and a new single write completes correctly.

Source files
------------

// File: rtl/slave_in_port.sv
// Serial bus slave front end: receives address and burst count serially,
// assembles serial write data into words and issues one-cycle memory
// strobes; aborts on grant loss, word overflow or data timeout.
module slave_in_port #(
  parameter int unsigned ADDR_LEN  = 12,
  parameter int unsigned DATA_LEN  = 8,
  parameter int unsigned BURST_LEN = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic                 approval_grant,
  input  logic                 rx_address,
  input  logic                 rx_burst_number,
  input  logic                 rx_data,
  input  logic                 master_valid,
  output logic                 slave_ready,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [BURST_LEN-1:0] burst_len,
  output logic                 rx_done,
  output logic                 error
);

  localparam int unsigned H  = (ADDR_LEN > BURST_LEN + 1) ? ADDR_LEN : BURST_LEN + 1;
  localparam int unsigned HW = $clog2(H + 1);
  localparam int unsigned DW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;
  state_t state, state_nx;

  logic [HW-1:0]        hdr_cnt;
  logic [DW-1:0]        bit_cnt;
  logic [3:0]           idle_cnt;
  logic [BURST_LEN-1:0] word_idx;
  logic [ADDR_LEN-1:0]  addr_q;
  logic [DATA_LEN-1:0]  acc_q;
  logic [DATA_LEN-1:0]  wbuf_q;
  logic                 pend_q;
  logic                 hdr_done_q;
  logic                 fin_q;
  logic                 wr_q;

  logic [ADDR_LEN-1:0]  addr_nx;
  logic [BURST_LEN-1:0] burst_nx;
  logic [DATA_LEN-1:0]  acc_nx;
  logic [BURST_LEN-1:0] words_exp;
  logic start, active, hdr_last, bit_in, word_done, do_write, is_last, abort;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic, serial capture and abort detection
  always_comb begin
    addr_nx   = addr_q;
    burst_nx  = burst_len;
    acc_nx    = acc_q;
    state_nx  = state;
    start     = (state == IDLE) && slave_ready && (write_en || read_en) && approval_grant;
    // fin_q marks a transaction already finished; later bits are ignored
    active    = ((state == HEADER) || (state == DATA)) && !fin_q;
    hdr_last  = (state == HEADER) && (hdr_cnt == HW'(H - 1));
    if (state == HEADER) begin
      for (int unsigned i = 0; i < ADDR_LEN; i++)
        if (32'(hdr_cnt) == i) addr_nx[i] = rx_address;
      // header bit 0 on the burst line is a marker and never stored
      for (int unsigned i = 0; i < BURST_LEN; i++)
        if (32'(hdr_cnt) == i + 1) burst_nx[i] = rx_burst_number;
    end
    bit_in    = active && wr_q && master_valid;
    word_done = bit_in && (bit_cnt == DW'(DATA_LEN - 1));
    if (bit_in) begin
      for (int unsigned i = 0; i < DATA_LEN; i++)
        if (32'(bit_cnt) == i) acc_nx[i] = rx_data;
    end
    do_write  = active && wr_q && pend_q && hdr_done_q;
    words_exp = (burst_len == '0) ? BURST_LEN'(1) : burst_len;
    is_last   = ((word_idx + BURST_LEN'(1)) == words_exp);
    abort     = active && (!approval_grant
                           || (word_done && pend_q && !do_write)
                           || ((state == DATA) && !master_valid && (idle_cnt == 4'hF)));
    case (state)
      IDLE:    if (start) state_nx = HEADER;
      HEADER:  if (abort) state_nx = IDLE;
               else if (hdr_last) state_nx = DATA;
      DATA:    if (abort) state_nx = IDLE;
               else if (fin_q) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slave_ready <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      burst_len   <= '0;
      rx_done     <= 1'b0;
      error       <= 1'b0;
      hdr_cnt     <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      word_idx    <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      wbuf_q      <= '0;
      pend_q      <= 1'b0;
      hdr_done_q  <= 1'b0;
      fin_q       <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      error       <= abort;
      rx_done     <= (state_nx == DONE);
      slave_ready <= (state_nx != DONE) && !abort;
      if (start) begin
        wr_q       <= write_en;
        hdr_cnt    <= '0;
        bit_cnt    <= '0;
        idle_cnt   <= '0;
        word_idx   <= '0;
        addr_q     <= '0;
        acc_q      <= '0;
        burst_len  <= '0;
        pend_q     <= 1'b0;
        hdr_done_q <= 1'b0;
        fin_q      <= 1'b0;
      end else if (abort) begin
        pend_q <= 1'b0;
      end else if (active) begin
        if (state == HEADER) begin
          addr_q    <= addr_nx;
          burst_len <= burst_nx;
          hdr_cnt   <= hdr_cnt + HW'(1);
          if (hdr_last) begin
            hdr_done_q <= 1'b1;
            if (!wr_q) begin
              mem_re   <= 1'b1;
              mem_addr <= addr_nx;
              fin_q    <= 1'b1;
            end
          end
        end
        if (state == DATA) idle_cnt <= master_valid ? 4'h0 : idle_cnt + 4'h1;
        if (bit_in) begin
          acc_q   <= acc_nx;
          bit_cnt <= word_done ? '0 : bit_cnt + DW'(1);
        end
        if (do_write) begin
          mem_we    <= 1'b1;
          mem_wdata <= wbuf_q;
          mem_addr  <= addr_q + ADDR_LEN'(word_idx);
          word_idx  <= word_idx + BURST_LEN'(1);
          if (is_last) fin_q <= 1'b1;
        end
        // a word completing in the same cycle the older one is written
        // simply takes over the buffer
        if (word_done) begin
          wbuf_q <= acc_nx;
          pend_q <= 1'b1;
        end else if (do_write) begin
          pend_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// Self-checking bench for slave_in_port: table of transactions plus
// hand-written abort, timeout and reset sequences.
module tb_slave_in_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en, read_en, approval_grant;
  logic        rx_address, rx_burst_number, rx_data, master_valid;
  logic        slave_ready, mem_we, mem_re, rx_done, error;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [11:0] burst_len;

  slave_in_port #(.ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
    .approval_grant(approval_grant), .rx_address(rx_address),
    .rx_burst_number(rx_burst_number), .rx_data(rx_data),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .burst_len(burst_len), .rx_done(rx_done), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Event log written only by the monitor
  int          cyc = 0;
  int          n_we = 0, n_re = 0, n_done = 0, n_err = 0;
  logic [11:0] we_addr[$];
  logic [7:0]  we_data[$];
  logic [11:0] re_addr;
  int          we_cyc, re_cyc, done_cyc, err_cyc;
  logic        ready_at_done, ready_at_err, ready_after_err, err_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (mem_we) begin we_addr.push_back(mem_addr); we_data.push_back(mem_wdata); n_we++; we_cyc = cyc; end
      if (mem_re) begin re_addr = mem_addr; n_re++; re_cyc = cyc; end
      if (rx_done) begin n_done++; done_cyc = cyc; ready_at_done = slave_ready; end
      if (err_prev) ready_after_err = slave_ready;
      if (error) begin n_err++; err_cyc = cyc; ready_at_err = slave_ready; end
      err_prev = error;
    end
  end

  typedef struct {
    logic             rd;
    logic [11:0]      addr;
    logic [11:0]      burst;
    logic [31:0]      words;
    int               nbits;
    int               exp_we;
    logic [2:0][11:0] exp_addr;
    logic [2:0][7:0]  exp_data;
    int               exp_re;
    logic [11:0]      exp_raddr;
    int               exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Drive one transaction: enable for the start edge, then ncyc header/data cycles
  task automatic txn(input logic rd, input logic [11:0] addr, input logic [11:0] burst,
                     input logic [31:0] words, input int nbits, input int drop_at, input int ncyc);
    for (int t = 0; t < 50 && !slave_ready; t++) begin
      @(posedge clk); #1;
    end
    if (!slave_ready) chk("ready_wait", {31'b0, slave_ready}, 32'd1);
    write_en = !rd; read_en = rd; approval_grant = 1'b1;
    @(posedge clk); #1;
    write_en = 1'b0; read_en = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      rx_address      = (k < 12) ? addr[k] : 1'b0;
      rx_burst_number = (k == 0) ? 1'b1 : ((k <= 12) ? burst[k-1] : 1'b0);
      master_valid    = !rd && (k < nbits);
      rx_data         = (k < nbits && k < 32) ? words[k] : 1'b1;
      approval_grant  = (drop_at < 0) || (k < drop_at);
      @(posedge clk); #1;
    end
    rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0;
    master_valid = 1'b0; approval_grant = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int we0, re0, d0, e0, got_we;
    we0 = n_we; re0 = n_re; d0 = n_done; e0 = n_err;
    txn(v.rd, v.addr, v.burst, v.words, v.nbits, -1, 40);
    repeat (3) @(posedge clk);
    #1;
    got_we = n_we - we0;
    chk({nm, "_we_count"}, got_we, v.exp_we);
    for (int i = 0; i < v.exp_we && i < got_we && i < 3; i++) begin
      chk($sformatf("%s_we%0d_addr", nm, i), {20'b0, we_addr[we0+i]}, {20'b0, v.exp_addr[i]});
      chk($sformatf("%s_we%0d_data", nm, i), {24'b0, we_data[we0+i]}, {24'b0, v.exp_data[i]});
    end
    chk({nm, "_re_count"}, n_re - re0, v.exp_re);
    if (v.exp_re > 0 && n_re > re0) chk({nm, "_re_addr"}, {20'b0, re_addr}, {20'b0, v.exp_raddr});
    chk({nm, "_done_count"}, n_done - d0, v.exp_done);
    chk({nm, "_err_count"}, n_err - e0, 0);
    if (v.exp_done > 0 && n_done > d0) begin
      chk({nm, "_done_latency"}, done_cyc - (v.rd ? re_cyc : we_cyc), 1);
      chk({nm, "_ready_in_done"}, {31'b0, ready_at_done}, 0);
    end
    chk({nm, "_burst_len"}, {20'b0, burst_len}, {20'b0, v.burst});
  endtask

  initial begin
    int we0, e0, d0;
    vecs[0] = '{1'b0, 12'h0A5, 12'd0, 32'h0000003C,  8, 1, {12'h000, 12'h000, 12'h0A5}, {8'h00, 8'h00, 8'h3C}, 0, 12'h000, 1};
    vecs[1] = '{1'b0, 12'hFFE, 12'd3, 32'h00332211, 24, 3, {12'h000, 12'hFFF, 12'hFFE}, {8'h33, 8'h22, 8'h11}, 0, 12'h000, 1};
    vecs[2] = '{1'b1, 12'h123, 12'd0, 32'h00000000,  0, 0, {12'h000, 12'h000, 12'h000}, {8'h00, 8'h00, 8'h00}, 1, 12'h123, 1};
    vecs[3] = '{1'b0, 12'h800, 12'd1, 32'h000000A5,  8, 1, {12'h000, 12'h000, 12'h800}, {8'h00, 8'h00, 8'hA5}, 0, 12'h000, 1};
    vecs[4] = '{1'b0, 12'h7FF, 12'd2, 32'h00000FF0, 16, 2, {12'h000, 12'h800, 12'h7FF}, {8'h00, 8'h0F, 8'hF0}, 0, 12'h000, 1};
    vecs[5] = '{1'b1, 12'hFFF, 12'd5, 32'h00000000,  0, 0, {12'h000, 12'h000, 12'h000}, {8'h00, 8'h00, 8'h00}, 1, 12'hFFF, 1};

    reset = 1'b0; write_en = 1'b0; read_en = 1'b0; approval_grant = 1'b0;
    rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0; master_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr_burst", {8'b0, mem_addr, burst_len}, 0);
    chk("rst_ctrl", {19'b0, slave_ready, mem_wdata, mem_we, mem_re, rx_done, error}, 0);
    reset = 1'b1;
    #1;
    chk("ready_before_edge", {31'b0, slave_ready}, 0);
    @(posedge clk); #1;
    chk("ready_after_release", {31'b0, slave_ready}, 1);

    // Table of normal transactions
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Grant dropped after 5 data bits
    we0 = n_we; e0 = n_err; d0 = n_done;
    txn(1'b0, 12'h055, 12'd0, 32'h000000FF, 5, 5, 20);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_err_count", n_err - e0, 1);
    chk("abort_we_count", n_we - we0, 0);
    chk("abort_done_count", n_done - d0, 0);
    chk("abort_ready_in_err", {31'b0, ready_at_err}, 0);
    chk("abort_ready_after", {31'b0, ready_after_err}, 1);

    // Burst of 2, second word never arrives
    we0 = n_we; e0 = n_err; d0 = n_done;
    txn(1'b0, 12'h300, 12'd2, 32'h0000005A, 8, -1, 40);
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_we_count", n_we - we0, 1);
    if (n_we > we0) chk("tmo_we_data", {24'b0, we_data[we0]}, 32'h5A);
    chk("tmo_err_count", n_err - e0, 1);
    chk("tmo_done_count", n_done - d0, 0);
    chk("tmo_err_delay", err_cyc - we_cyc, 15);

    // Reset in the middle of a burst-4 write
    txn(1'b0, 12'h3A0, 12'd4, 32'h44332211, 32, -1, 20);
    reset = 1'b0;
    #2;
    chk("midrst_addr_burst", {8'b0, mem_addr, burst_len}, 0);
    chk("midrst_ctrl", {19'b0, slave_ready, mem_wdata, mem_we, mem_re, rx_done, error}, 0);
    we0 = n_we;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_hold_ctrl", {19'b0, slave_ready, mem_wdata, mem_we, mem_re, rx_done, error}, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready_after", {31'b0, slave_ready}, 1);
    chk("midrst_no_strobe", n_we - we0, 0);
    run_vec(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
